// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: groups the pipeline-side hazard inputs and the stage
// control outputs of the stall/flush sequencer into one bundle.
//   master : the pipeline datapath (drives hazard info, receives controls)
//   slave  : pipeline_ctrl (receives hazard info, drives controls)
//   if_id_instr/if_id_valid   instruction currently in IF/ID
//   id_ex_rd/id_ex_memread    destination and load flag of the EX instruction
//   branch_taken              branch/jump in EX resolved taken
//   mem_busy                  data memory not ready
//   pc_we/if_id_we/ex_mem_we  stage write enables
//   if_id_flush/id_ex_flush   stage bubble inserts
//   halted/stall_cycles       status
interface pipeline_ctrl_if;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic [3:0]  id_ex_rd;
  logic        id_ex_memread;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_we;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output if_id_instr, if_id_valid, id_ex_rd, id_ex_memread, branch_taken, mem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, halted, stall_cycles
  );

  modport slave (
    input  if_id_instr, if_id_valid, id_ex_rd, id_ex_memread, branch_taken, mem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage 16-bit pipeline.
// Merges memory wait, taken branch, load-use hazard and HLT into one set of
// per-stage enables/flushes, runs the halt drain sequence and counts stalls.
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pipeline_ctrl_if.slave (hazard inputs, control/status outputs)
// Parameters:
//   LU_STALL     : bubbles inserted per load-use hazard (1..3)
//   DRAIN_CYCLES : unstalled cycles HLT is held before halting (1..7)
module pipeline_ctrl #(
  parameter int LU_STALL     = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    LU_WAIT,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [2:0] LU_INIT    = 3'(LU_STALL - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_q, stall_d;

  logic [3:0] opcode, rs, rt;
  logic       lu, hd;
  logic       pc_we_c, if_id_we_c, if_id_flush_c, id_ex_flush_c, ex_mem_we_c;
  logic       unused_ok;

  assign opcode    = bus.if_id_instr[15:12];
  assign rs        = bus.if_id_instr[7:4];
  assign rt        = bus.if_id_instr[3:0];
  // Bits [11:8] carry the destination field, which never creates a hazard here.
  assign unused_ok = ^bus.if_id_instr[11:8];

  // R0 is hardwired to zero, so a load into it can never be a true dependency.
  assign lu = bus.id_ex_memread & bus.if_id_valid & (opcode != 4'hF) &
              (bus.id_ex_rd != 4'd0) & ((rs == bus.id_ex_rd) | (rt == bus.id_ex_rd));
  assign hd = bus.if_id_valid & (opcode == 4'hF);

  // Next-state and Mealy control outputs. Memory wait freezes everything,
  // a taken branch overrides any pending stall or drain (the HLT behind it is
  // wrong-path), then load-use, then halt detection.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_we_c       = 1'b1;
    if_id_we_c    = 1'b1;
    ex_mem_we_c   = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;

    if (state_q == HALTED) begin
      pc_we_c     = 1'b0;
      if_id_we_c  = 1'b0;
      ex_mem_we_c = 1'b0;
    end else if (bus.mem_busy) begin
      pc_we_c     = 1'b0;
      if_id_we_c  = 1'b0;
      ex_mem_we_c = 1'b0;
    end else if (bus.branch_taken) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      state_d       = RUN;
      cnt_d         = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_flush_c = 1'b1;
            if (LU_STALL > 1) begin
              state_d = LU_WAIT;
              cnt_d   = LU_INIT;
            end
          end else if (hd) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_flush_c = 1'b1;
            state_d       = DRAIN;
            cnt_d         = DRAIN_INIT;
          end
        end
        LU_WAIT, DRAIN: begin
          pc_we_c       = 1'b0;
          if_id_we_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          cnt_d         = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = (state_q == DRAIN) ? HALTED : RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    halted_d = (state_d == HALTED);

    stall_d = stall_q;
    if (!pc_we_c && (state_q != HALTED) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State, shared counter, halt flag and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      halted_q <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  // While reset is held every stage is frozen, independent of the clock.
  assign bus.pc_we        = pc_we_c & rst;
  assign bus.if_id_we     = if_id_we_c & rst;
  assign bus.ex_mem_we    = ex_mem_we_c & rst;
  assign bus.if_id_flush  = if_id_flush_c & rst;
  assign bus.id_ex_flush  = id_ex_flush_c & rst;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: drives two pipeline_ctrl instances (LU_STALL=1 and
// LU_STALL=3, both DRAIN_CYCLES=3) with identical stimulus and checks them
// every cycle against a bubble-count reference model, plus directed scenarios
// with hand-computed expectations.
module tb_pipeline_ctrl;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        valid;
  logic [3:0]  rd;
  logic        memread, br, busy;

  int checks = 0;
  int passes = 0;

  pipeline_ctrl_if bus0 ();
  pipeline_ctrl_if bus1 ();

  assign bus0.if_id_instr   = instr;
  assign bus0.if_id_valid   = valid;
  assign bus0.id_ex_rd      = rd;
  assign bus0.id_ex_memread = memread;
  assign bus0.branch_taken  = br;
  assign bus0.mem_busy      = busy;
  assign bus1.if_id_instr   = instr;
  assign bus1.if_id_valid   = valid;
  assign bus1.id_ex_rd      = rd;
  assign bus1.id_ex_memread = memread;
  assign bus1.branch_taken  = br;
  assign bus1.mem_busy      = busy;

  pipeline_ctrl #(.LU_STALL(1), .DRAIN_CYCLES(DRAIN)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  pipeline_ctrl #(.LU_STALL(3), .DRAIN_CYCLES(DRAIN)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: each instance tracks how many forced bubbles remain from
  // a load-use hazard and how many drain cycles remain before halting.
  int   lu_left [2];
  int   drain_left [2];
  int   m_stall [2];
  bit   m_halted [2];
  int   lu_stall_p [2] = '{1, 3};
  logic is_lu, is_hd;
  logic [5:0] exp_v, act_v;
  int   act_stall;

  // Output bit order: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, halted}
  always @(negedge clk) begin
    is_lu = memread && valid && (instr[15:12] != 4'hF) && (rd != 4'd0) &&
            ((instr[7:4] == rd) || (instr[3:0] == rd));
    is_hd = valid && (instr[15:12] == 4'hF);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        lu_left[k] = 0; drain_left[k] = 0; m_stall[k] = 0; m_halted[k] = 1'b0;
        exp_v = 6'b000000;
      end else if (m_halted[k]) begin
        exp_v = 6'b000001;
      end else if (busy) begin
        exp_v = 6'b000000;
      end else if (br) begin
        exp_v = 6'b111110;
      end else if (lu_left[k] > 0 || drain_left[k] > 0 || is_lu || is_hd) begin
        exp_v = 6'b000110;
      end else begin
        exp_v = 6'b110010;
      end

      if (k == 0) begin
        act_v = {bus0.pc_we, bus0.if_id_we, bus0.if_id_flush, bus0.id_ex_flush, bus0.ex_mem_we, bus0.halted};
        act_stall = int'(bus0.stall_cycles);
      end else begin
        act_v = {bus1.pc_we, bus1.if_id_we, bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_we, bus1.halted};
        act_stall = int'(bus1.stall_cycles);
      end
      checkOutput(k == 0 ? "model ctrl dut0" : "model ctrl dut1", int'(act_v), int'(exp_v));
      checkOutput(k == 0 ? "model stall dut0" : "model stall dut1", act_stall, m_stall[k]);

      if (rst && !m_halted[k]) begin
        if (!exp_v[5] && m_stall[k] < 65535) m_stall[k]++;
        if (!busy) begin
          if (br) begin
            lu_left[k] = 0; drain_left[k] = 0;
          end else if (lu_left[k] > 0) begin
            lu_left[k]--;
          end else if (drain_left[k] > 0) begin
            drain_left[k]--;
            if (drain_left[k] == 0) m_halted[k] = 1'b1;
          end else if (is_lu) begin
            lu_left[k] = lu_stall_p[k] - 1;
          end else if (is_hd) begin
            drain_left[k] = DRAIN;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] i, input logic v, input logic [3:0] r,
                               input logic m, input logic b, input logic bz);
    @(posedge clk);
    #1;
    instr = i; valid = v; rd = r; memread = m; br = b; busy = bz;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr = 16'h0000; valid = 1'b0; rd = 4'd0; memread = 1'b0; br = 1'b0; busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  int low0, low1, bad;
  logic [3:0] op;

  initial begin
    rst = 1'b0;
    instr = 16'h0000; valid = 1'b0; rd = 4'd0; memread = 1'b0; br = 1'b0; busy = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset pc_we", int'(bus0.pc_we), 0);
    checkOutput("reset ex_mem_we", int'(bus1.ex_mem_we), 0);
    checkOutput("reset stall_cycles", int'(bus0.stall_cycles), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post-reset pc_we", int'(bus0.pc_we), 1);

    // Load-use rd=3, rs=3: one bubble for LU_STALL=1, three for LU_STALL=3.
    doReset();
    applyStimulus(16'h1030, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("lu id_ex_flush dut0", int'(bus0.id_ex_flush), 1);
    low0 = int'(!bus0.pc_we); low1 = int'(!bus1.pc_we);
    for (int c = 0; c < 5; c++) begin
      idle();
      low0 += int'(!bus0.pc_we); low1 += int'(!bus1.pc_we);
    end
    checkOutput("lu bubbles LU_STALL=1", low0, 1);
    checkOutput("lu bubbles LU_STALL=3", low1, 3);
    checkOutput("lu stall_cycles dut0", int'(bus0.stall_cycles), 1);
    checkOutput("lu stall_cycles dut1", int'(bus1.stall_cycles), 3);
    applyStimulus(16'h1000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu rd=0 pc_we", int'(bus0.pc_we), 1);

    // Memory wait in the middle of a 3-cycle load-use stall.
    doReset();
    applyStimulus(16'h1030, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    low0 = int'(!bus0.pc_we); low1 = int'(!bus1.pc_we);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      low0 += int'(!bus0.pc_we); low1 += int'(!bus1.pc_we);
    end
    checkOutput("busy ex_mem_we dut1", int'(bus1.ex_mem_we), 0);
    for (int c = 0; c < 4; c++) begin
      idle();
      low0 += int'(!bus0.pc_we); low1 += int'(!bus1.pc_we);
    end
    checkOutput("busy-lu stalled cycles dut1", low1, 5);
    checkOutput("busy-lu stalled cycles dut0", low0, 3);
    checkOutput("busy-lu stall_cycles dut1", int'(bus1.stall_cycles), 5);

    // Halt drain: 4 stalled cycles then halted sticks regardless of inputs.
    doReset();
    low0 = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(16'hF000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      low0 += int'(!bus0.pc_we);
    end
    checkOutput("drain stalled cycles", low0, 4);
    checkOutput("halted before final edge", int'(bus0.halted), 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      if (!bus0.halted || bus0.pc_we || bus0.if_id_flush || bus1.id_ex_flush) bad++;
    end
    checkOutput("halted held cycles bad", bad, 0);
    checkOutput("halted stall_cycles", int'(bus0.stall_cycles), 4);

    // Wrong-path HLT cancelled by a branch in the second drain cycle.
    doReset();
    applyStimulus(16'hF000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hF000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hF000, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrong-path pc_we", int'(bus0.pc_we), 1);
    checkOutput("wrong-path if_id_flush", int'(bus0.if_id_flush), 1);
    checkOutput("wrong-path id_ex_flush", int'(bus0.id_ex_flush), 1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      bad += int'(bus0.halted);
    end
    checkOutput("wrong-path halted cycles", bad, 0);

    // Branch and load-use in the same cycle: branch wins, no extra bubbles.
    doReset();
    applyStimulus(16'h1030, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("collision pc_we", int'(bus1.pc_we), 1);
    checkOutput("collision if_id_flush", int'(bus1.if_id_flush), 1);
    idle();
    checkOutput("collision next pc_we", int'(bus1.pc_we), 1);

    // Asynchronous reset in the middle of DRAIN.
    doReset();
    applyStimulus(16'hF000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst id_ex_flush", int'(bus0.id_ex_flush), 0);
    checkOutput("async rst stall_cycles", int'(bus0.stall_cycles), 0);
    checkOutput("async rst halted", int'(bus0.halted), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("after rst release pc_we", int'(bus0.pc_we), 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst     = ($urandom_range(99) != 0);
      valid   = ($urandom_range(9) < 8);
      op      = ($urandom_range(19) == 0) ? 4'hF : 4'($urandom_range(14));
      instr   = {op, 4'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)};
      rd      = {1'b0, 3'($urandom)};
      memread = ($urandom_range(9) < 3);
      br      = ($urandom_range(9) == 0);
      busy    = ($urandom_range(99) < 15);
    end

    // Saturation of the stall counter under a long memory wait.
    doReset();
    @(posedge clk);
    #1;
    busy = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checkOutput("saturated stall_cycles dut0", int'(bus0.stall_cycles), 65535);
    checkOutput("saturated stall_cycles dut1", int'(bus1.stall_cycles), 65535);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage 16-bit pipeline. Each cycle it combines the load-use hazard, the taken branch resolved in EX, data-memory wait, and HLT detection in IF/ID into one consistent set of per-stage write-enables and flushes. It also runs the halt drain sequence, which holds HLT in IF/ID until older instructions retire, and keeps a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable and flush inputs directly.

## Interface
- LU_STALL, 1, load-use bubble cycles per hazard (legal 1..3)
- DRAIN_CYCLES, 3, unstalled cycles HLT is held in IF/ID before `halted` (legal 1..7)

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_id_instr  in  16  instruction in IF/ID; opcode [15:12], rs [7:4], rt [3:0]; opcode 4'hF = HLT
- if_id_valid  in  1  IF/ID holds a real instruction
- id_ex_rd  in  4  destination register of the instruction in EX
- id_ex_memread  in  1  instruction in EX is a load
- branch_taken  in  1  branch/jump in EX resolved taken
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  clear IF/ID to a bubble
- id_ex_flush  out  1  clear ID/EX to a bubble
- ex_mem_we  out  1  EX/MEM and MEM/WB write enable
- halted  out  1  processor halted, registered
- stall_cycles  out  16  saturating count of stalled cycles

## Operation
- States: RUN, LU_WAIT, DRAIN, HALTED. A 3-bit down-counter `cnt` is shared by LU_WAIT and DRAIN.
- Load-use hazard (`lu`) = id_ex_memread & if_id_valid & opcode≠4'hF & id_ex_rd≠0 & (rs==id_ex_rd | rt==id_ex_rd). R0 never hazards.
- HLT detect (`hd`) = if_id_valid & opcode==4'hF.
- Default outputs: pc_we=1, if_id_we=1, ex_mem_we=1, both flushes 0.
- Priority is highest first: mem_busy, then branch_taken, then load-use stall, then halt.
- mem_busy=1 in any state except HALTED:
  - All write enables are 0 and both flushes are 0.
  - State and `cnt` hold; branch_taken is ignored that cycle.
- branch_taken (RUN, LU_WAIT or DRAIN):
  - pc_we=1, if_id_flush=1, id_ex_flush=1.
  - Next state is RUN and `cnt` clears. This cancels a pending stall or drain, because the wrong-path HLT is discarded.
- RUN & lu:
  - pc_we=0, if_id_we=0, id_ex_flush=1.
  - If LU_STALL>1, go to LU_WAIT with cnt=LU_STALL-1; otherwise stay in RUN.
- LU_WAIT:
  - Same stall outputs as RUN & lu.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
- RUN & hd & !lu:
  - pc_we=0, if_id_we=0, id_ex_flush=1.
  - Go to DRAIN with cnt=DRAIN_CYCLES.
- DRAIN:
  - Same stall outputs.
  - cnt decrements each cycle; when cnt==1, next state is HALTED.
- HALTED:
  - pc_we=0, if_id_we=0, ex_mem_we=0, flushes 0, halted=1.
  - All inputs are ignored, including mem_busy and branch_taken. The only exit is reset.
- stall_cycles increments on every cycle with pc_we=0 and state≠HALTED, including mem_busy cycles. It saturates at 16'hFFFF.

## Timing
- Control outputs are combinational (Mealy) from state and current inputs. The stall or flush is visible in the same cycle the hazard appears.
- State, cnt, halted and stall_cycles update on the rising edge of clk.
- halted rises on the edge that enters HALTED. With mem_busy=0 throughout, that is DRAIN_CYCLES+1 cycles after the first cycle HLT is seen in IF/ID.
- A load-use hazard costs exactly LU_STALL bubbles when mem_busy=0.
- Reset (rst=0, any time, including mid-DRAIN or mid-LU_WAIT):
  - Immediately: state=RUN, cnt=0, halted=0, stall_cycles=0.
  - All write enables are forced to 0 and flushes to 0 while rst=0.
- Release is synchronous to the next rising edge.

## Test plan
- Load-use, LU_STALL=1: EX=load rd=3, IF/ID rs=3 -> exactly 1 cycle with pc_we=0 and id_ex_flush=1, then normal flow; stall_cycles=1. Repeat with rd=0 -> no stall.
- Load-use, LU_STALL=3: same stimulus -> 3 consecutive stall cycles, then RUN. Add mem_busy=1 for 2 cycles mid-stall -> 5 stalled cycles total, all enables 0 during busy, stall_cycles=5.
- Halt drain, DRAIN_CYCLES=3: HLT valid in IF/ID -> 4 stall cycles, then halted=1 and stays 1 for 20 cycles regardless of inputs, including branch_taken=1.
- Wrong-path HLT: HLT in IF/ID, branch_taken=1 in the 2nd DRAIN cycle -> that cycle shows pc_we=1 and both flushes=1; next state RUN, halted never asserts.
- Branch vs. load-use collision: lu and branch_taken in the same cycle -> pc_we=1, both flushes=1, no LU_WAIT entry.
- Reset mid-DRAIN, then counter saturation: rst=0 asynchronously mid-DRAIN -> outputs clear without waiting for a clock edge. Separately, hold mem_busy=1 for 70000 cycles -> stall_cycles saturates at 65535.
